// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } dmem_op_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: one synchronous write port, one asynchronous read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [31:0]                    wr_data,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // NOTE: storage has no reset; clearing it would cost a reset net on every word for no functional gain.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Accepts one load/store at a time, stalls the pipeline for a fixed latency, then
// commits the store or registers the load data in a single DONE cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        mem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OFS_W = $clog2(WORD_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_op_t         op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             misal_q, misal_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             mem_err_q, mem_err_d;

    logic             req;
    logic             arr_we;
    logic [31:0]      arr_rd_data;
    logic             unused_addr_bits;

    assign req              = mem_read | mem_write;
    // Upper address bits fold away so accesses wrap modulo the array size.
    assign unused_addr_bits = ^address[31:IDX_W+OFS_W];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        misal_d     = misal_q;
        read_data_d = read_data_q;
        mem_err_d   = mem_err_q;
        arr_we      = 1'b0;
        stall       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    op_d    = mem_write ? OP_STORE : OP_LOAD;
                    idx_d   = address[IDX_W+OFS_W-1:OFS_W];
                    wdata_d = write_data;
                    misal_d = |address[OFS_W-1:0];
                    if ((|address[OFS_W-1:0]) || (mem_read && mem_write)) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // A misaligned store still takes the full latency but never reaches the array.
                    if (op_q == OP_STORE) begin
                        arr_we = ~misal_q;
                    end else begin
                        read_data_d = arr_rd_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= OP_LOAD;
            idx_q       <= '0;
            wdata_q     <= '0;
            misal_q     <= 1'b0;
            read_data_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            misal_q     <= misal_d;
            read_data_q <= read_data_d;
            mem_err_q   <= mem_err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .wr_idx (idx_q),
        .wr_data(wdata_q),
        .rd_idx (idx_q),
        .rd_data(arr_rd_data)
    );

    assign read_data = read_data_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: the driver pushes expected completion results from a word-level memory
// model; a monitor pops and compares them whenever a stall run ends in a DONE cycle.
module tb_dmem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        mem_err;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .stall     (stall),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          done_cyc[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rd;
    logic        model_err;
    int          checks;
    int          failures;
    int          cyc;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: a stall run followed by a low sample marks the DONE cycle.
    initial begin
        int   run;
        logic prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (stall) begin
                    run++;
                end else if (prev) begin
                    done_cyc.push_back(cyc);
                    check("stall_cycles", 32'(run), 32'(LATENCY + 1));
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("read_data", read_data, e.rd);
                        check("mem_err", {31'b0, mem_err}, {31'b0, e.err});
                    end
                    run = 0;
                end
                prev = stall;
            end
        end
    end

    task automatic model_reset();
        model_rd  = '0;
        model_err = 1'b0;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data);
        int   widx;
        int   n;
        logic seen;
        exp_t e;
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = data;

        widx = int'((addr / 4) % DEPTH_WORDS);
        if ((addr % 4) != 0 || (rd && wr)) model_err = 1'b1;
        if (wr) begin
            if ((addr % 4) == 0) model_mem[widx] = data;
        end else begin
            model_rd = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
        end
        e.rd  = model_rd;
        e.err = model_err;
        exp_q.push_back(e);

        // The request stays presented through DONE, as a frozen pipeline would.
        seen = 1'b0;
        n    = 0;
        forever begin
            @(negedge clk);
            n++;
            if (stall) seen = 1'b1;
            else if (seen) break;
            if (n > 50) begin
                check("access_timeout", 32'(n), 32'(LATENCY + 2));
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_read_data", read_data, 32'h0);
        check("reset_mem_err", {31'b0, mem_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_stall", {31'b0, stall}, 32'h0);

        // Store then load.
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h10, 32'h0);

        // Back-to-back with no gap cycles: DONE cycles are LATENCY+2 apart.
        done_cyc.delete();
        do_access(1'b0, 1'b1, 32'h0, 32'h1);
        do_access(1'b0, 1'b1, 32'h4, 32'h2);
        do_access(1'b1, 1'b0, 32'h4, 32'h0);
        check("b2b_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            check("b2b_spacing0", 32'(done_cyc[1] - done_cyc[0]), 32'(LATENCY + 2));
            check("b2b_spacing1", 32'(done_cyc[2] - done_cyc[1]), 32'(LATENCY + 2));
        end
        check("b2b_final_read", read_data, 32'h2);

        // No re-sample: after DONE the request is gone and stall must stay low.
        @(negedge clk);
        check("no_resample_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;

        // Address wrap.
        do_access(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5);
        do_access(1'b1, 1'b0, 32'h0, 32'h0);

        // Misaligned store is suppressed and sets the sticky error.
        do_access(1'b0, 1'b1, 32'h20, 32'h11111111);
        do_access(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF);
        do_access(1'b1, 1'b0, 32'h20, 32'h0);
        check("err_sticky", {31'b0, mem_err}, 32'h1);

        // Reset during the second WAIT cycle discards the pending store.
        do_access(1'b0, 1'b1, 32'h8, 32'h0);
        mem_write  = 1'b1;
        address    = 32'h8;
        write_data = 32'h55;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        mem_write = 1'b0;
        #1;
        check("abort_stall", {31'b0, stall}, 32'h0);
        check("abort_read_data", read_data, 32'h0);
        check("abort_mem_err", {31'b0, mem_err}, 32'h0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'h8, 32'h0);

        // Read+write collision behaves as a store and flags an error.
        do_access(1'b1, 1'b1, 32'hC, 32'h77);
        do_access(1'b1, 1'b0, 32'hC, 32'h0);

        // Randomised traffic over a preloaded window, with wrapped aliases.
        for (int i = 0; i < 32; i++) begin
            do_access(1'b0, 1'b1, 32'(i * 4), $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 15));
            a    = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3) * 4096);
            if (kind == 1 || kind == 2) a = a + 32'($urandom_range(1, 3));
            if (kind == 0) do_access(1'b1, 1'b1, a, $urandom);
            else if (kind[0]) do_access(1'b1, 1'b0, a, 32'h0);
            else do_access(1'b0, 1'b1, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
